// File: rtl/branch_ctrl.sv
// branch_ctrl
// Branch and run-control stage sitting directly upstream of the fetch PC
// register. Decodes the 9-bit instruction from the synchronous ROM,
// evaluates BEQZ/BNEZ/BLTZ against a registered Z/N flag pair, looks up a
// signed branch offset in a 32-entry table and runs the start/done
// handshake. The instruction after every taken branch is squashed.
//
// Ports
//   CLK, reset               clock (rising edge), async active-high reset
//   start                    run request (level)
//   instr[8:0]               instruction, opcode = instr[8:5]
//   flag_we, alu_zero,       ALU flag update strobe and flag values
//   alu_neg
//   lut_we, lut_waddr[4:0],  offset table write port, data = {sign, magnitude}
//   lut_wdata[OFF_W:0]       (accepted only while idle or halted)
//   branch_en, bSIGN,        combinational branch request to the PC register;
//   bOFFSET[OFF_W-1:0]       bSIGN=1 means PC - offset, all zero when not taken
//   init, halt, squash, done state decodes
//
// Optional feature: define BRANCH_STATS_EN to add taken_cnt[15:0] and
// cycle_cnt[15:0] (saturating taken-branch and RUN+FLUSH cycle counters).

module branch_ctrl #(
    parameter int unsigned LUT_DEPTH = 32,
    parameter int unsigned OFF_W     = 9
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             start,
    input  logic [8:0]       instr,
    input  logic             flag_we,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             lut_we,
    input  logic [4:0]       lut_waddr,
    input  logic [OFF_W:0]   lut_wdata,
    output logic             branch_en,
    output logic             bSIGN,
    output logic [OFF_W-1:0] bOFFSET,
    output logic             init,
    output logic             halt,
    output logic             squash,
    output logic             done
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]      taken_cnt,
    output logic [15:0]      cycle_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FLUSH,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_BEQZ = 4'hC;
    localparam logic [3:0] OP_BNEZ = 4'hD;
    localparam logic [3:0] OP_BLTZ = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t         state;
    logic           flag_z;
    logic           flag_n;
    logic [OFF_W:0] lut [LUT_DEPTH];

    logic [3:0]     opcode;
    logic           cond;
    logic           taken;
    logic [OFF_W:0] entry;

    // Branch decision: uses flags registered before this edge, never the
    // same-cycle ALU result. A dropped start aborts and blocks the branch.
    always_comb begin
        opcode = instr[8:5];
        cond   = 1'b0;
        case (opcode)
            OP_BEQZ: cond = flag_z;
            OP_BNEZ: cond = ~flag_z;
            OP_BLTZ: cond = flag_n;
            default: cond = 1'b0;
        endcase
        taken     = (state == S_RUN) && start && cond;
        entry     = lut[instr[4:0]];
        branch_en = taken;
        bSIGN     = taken ? entry[OFF_W] : 1'b0;
        bOFFSET   = taken ? entry[OFF_W-1:0] : '0;
    end

    // Control FSM plus flag register.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
        end else begin
            // Flags only follow the ALU for real RUN-state instructions;
            // the squashed instruction in FLUSH must not disturb them.
            if (state == S_RUN && flag_we) begin
                flag_z <= alu_zero;
                flag_n <= alu_neg;
            end
            case (state)
                S_IDLE: begin
                    if (start) state <= S_RUN;
                end
                S_RUN: begin
                    if (!start)                state <= S_IDLE;
                    else if (taken)            state <= S_FLUSH;
                    else if (opcode == OP_HALT) state <= S_HALTED;
                end
                S_FLUSH: begin
                    state <= start ? S_RUN : S_IDLE;
                end
                S_HALTED: begin
                    if (!start) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Offset table: not reset, writable only while the program is stopped.
    always_ff @(posedge CLK) begin
        if (lut_we && (state == S_IDLE || state == S_HALTED))
            lut[lut_waddr] <= lut_wdata;
    end

    assign init   = (state == S_IDLE) || (state == S_HALTED);
    assign halt   = (state == S_HALTED);
    assign done   = (state == S_HALTED);
    assign squash = (state == S_FLUSH);

`ifdef BRANCH_STATS_EN
    // Cleared on run start, saturating, naturally frozen outside RUN/FLUSH.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            taken_cnt <= '0;
            cycle_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            taken_cnt <= '0;
            cycle_cnt <= '0;
        end else begin
            if ((state == S_RUN || state == S_FLUSH) && cycle_cnt != '1)
                cycle_cnt <= cycle_cnt + 16'd1;
            if (taken && taken_cnt != '1)
                taken_cnt <= taken_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: directed scenarios followed by randomized
// stimulus, all compared against a behavioural model of the run control.
module tb_branch_ctrl;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [8:0] instr = '0;
    logic       flag_we = 1'b0;
    logic       alu_zero = 1'b0;
    logic       alu_neg = 1'b0;
    logic       lut_we = 1'b0;
    logic [4:0] lut_waddr = '0;
    logic [9:0] lut_wdata = '0;
    logic       branch_en, bSIGN, init, halt, squash, done;
    logic [8:0] bOFFSET;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt, cycle_cnt;
`endif

    branch_ctrl #(.LUT_DEPTH(32), .OFF_W(9)) dut (
        .CLK(CLK), .reset(reset), .start(start), .instr(instr),
        .flag_we(flag_we), .alu_zero(alu_zero), .alu_neg(alu_neg),
        .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
        .branch_en(branch_en), .bSIGN(bSIGN), .bOFFSET(bOFFSET),
        .init(init), .halt(halt), .squash(squash), .done(done)
`ifdef BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .cycle_cnt(cycle_cnt)
`endif
    );

    always #5 CLK = ~CLK;

    localparam logic [8:0] NOP = 9'h000;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Behavioural model: program running (active), wrong-path slot pending
    // (shadow), program stopped by HALT (stopped), flags, table, counters.
    logic [9:0]  m_lut [32];
    bit          m_active, m_shadow, m_stopped, m_z, m_n;
    int unsigned m_taken, m_cycles;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_taken();
        bit c;
        case (instr[8:5])
            4'hC:    c = m_z;
            4'hD:    c = !m_z;
            4'hE:    c = m_n;
            default: c = 1'b0;
        endcase
        return m_active && !m_shadow && (start == 1'b1) && c;
    endfunction

    task automatic compare_all();
        bit         t;
        logic [9:0] e;
        t = model_taken();
        e = t ? m_lut[instr[4:0]] : 10'd0;
        check("branch_en", branch_en, t);
        check("bSIGN", bSIGN, e[9]);
        check("bOFFSET", bOFFSET, e[8:0]);
        check("init", init, !m_active);
        check("halt", halt, m_stopped);
        check("done", done, m_stopped);
        check("squash", squash, m_shadow);
`ifdef BRANCH_STATS_EN
        check("taken_cnt", taken_cnt, m_taken);
        check("cycle_cnt", cycle_cnt, m_cycles);
`endif
    endtask

    task automatic model_step();
        bit t;
        t = model_taken();
        if (m_active) begin
            if (m_cycles < 65535) m_cycles++;
            if (t && m_taken < 65535) m_taken++;
            if (flag_we && !m_shadow) begin
                m_z = alu_zero;
                m_n = alu_neg;
            end
            if (!start) begin
                m_active = 0;
                m_shadow = 0;
            end else if (m_shadow) begin
                m_shadow = 0;
            end else if (t) begin
                m_shadow = 1;
            end else if (instr[8:5] == 4'hF) begin
                m_active  = 0;
                m_stopped = 1;
            end
        end else begin
            if (lut_we) m_lut[lut_waddr] = lut_wdata;
            if (m_stopped) begin
                if (!start) m_stopped = 0;
            end else if (start) begin
                m_active = 1;
                m_taken  = 0;
                m_cycles = 0;
            end
        end
    endtask

    task automatic settle(input logic s, input logic [8:0] ins, input logic fwe,
                          input logic az, input logic an, input logic lwe,
                          input logic [4:0] wa, input logic [9:0] wd);
        @(negedge CLK);
        start = s; instr = ins; flag_we = fwe; alu_zero = az; alu_neg = an;
        lut_we = lwe; lut_waddr = wa; lut_wdata = wd;
        #1 compare_all();
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step();
    endtask

    task automatic step(input logic s, input logic [8:0] ins, input logic fwe,
                        input logic az, input logic an, input logic lwe,
                        input logic [4:0] wa, input logic [9:0] wd);
        settle(s, ins, fwe, az, an, lwe, wa, wd);
        tick();
    endtask

    // Reset spans one rising edge and is released before the next falling
    // edge, so no unmodelled edge occurs.
    task automatic do_reset();
        @(negedge CLK);
        reset = 1'b1;
        lut_we = 1'b0;
        m_active = 0; m_shadow = 0; m_stopped = 0; m_z = 0; m_n = 0;
        m_taken = 0; m_cycles = 0;
        #1 compare_all();
        check("rst_init", init, 1'b1);
        @(posedge CLK);
        #1 compare_all();
        #1 reset = 1'b0;
    endtask

    initial begin
        logic [8:0] ri;
        logic [3:0] op;

        do_reset();
        for (int i = 0; i < 32; i++)
            step(0, NOP, 0, 0, 0, 1, 5'(i), 10'($urandom));
        step(0, NOP, 0, 0, 0, 1, 5'd3, 10'h205);

        // BEQZ taken with Z=1, then the squashed slot ignores HALT
        settle(1, NOP, 0, 0, 0, 0, 0, 0); check("idle_init", init, 1'b1); tick();
        settle(1, NOP, 1, 1, 0, 0, 0, 0); check("run_init", init, 1'b0); tick();
        settle(1, 9'h183, 0, 0, 0, 0, 0, 0);
        check("beqz_en", branch_en, 1'b1);
        check("beqz_sign", bSIGN, 1'b1);
        check("beqz_off", bOFFSET, 9'd5);
        tick();
        settle(1, 9'h1E0, 1, 0, 1, 0, 0, 0);
        check("flush_squash", squash, 1'b1);
        check("flush_en", branch_en, 1'b0);
        tick();
        settle(1, NOP, 1, 0, 0, 0, 0, 0);
        check("flush_halt_ign", halt, 1'b0);
        check("post_flush_sq", squash, 1'b0);
        tick();

        // Z=0: BEQZ not taken, BNEZ taken
        settle(1, 9'h183, 0, 0, 0, 0, 0, 0); check("beqz_nt", branch_en, 1'b0); tick();
        settle(1, 9'h1A3, 0, 0, 0, 0, 0, 0);
        check("nt_no_squash", squash, 1'b0);
        check("bnez_en", branch_en, 1'b1);
        tick();
        step(1, NOP, 0, 0, 0, 0, 0, 0);

        // BLTZ sees registered N, not the same-cycle ALU value
        settle(1, 9'h1C3, 1, 0, 1, 0, 0, 0); check("bltz_same", branch_en, 1'b0); tick();
        settle(1, 9'h1C3, 0, 0, 0, 0, 0, 0); check("bltz_next", branch_en, 1'b1); tick();
        step(1, NOP, 0, 0, 0, 0, 0, 0);

        // HALT and the done handshake
        step(1, 9'h1E0, 0, 0, 0, 0, 0, 0);
        settle(1, NOP, 0, 0, 0, 0, 0, 0);
        check("halted_halt", halt, 1'b1);
        check("halted_done", done, 1'b1);
        check("halted_init", init, 1'b1);
        tick();
        settle(0, NOP, 0, 0, 0, 0, 0, 0); check("done_hold", done, 1'b1); tick();
        settle(0, NOP, 0, 0, 0, 0, 0, 0);
        check("done_fall", done, 1'b0);
        check("idle_after", init, 1'b1);
        tick();

        // Table write during RUN is ignored
        step(1, NOP, 0, 0, 0, 0, 0, 0);
        step(1, NOP, 0, 0, 0, 1, 5'd3, 10'h0FF);
        step(1, NOP, 1, 1, 0, 0, 0, 0);
        settle(1, 9'h183, 0, 0, 0, 0, 0, 0);
        check("lut_run_sign", bSIGN, 1'b1);
        check("lut_run_off", bOFFSET, 9'd5);
        tick();
        step(1, NOP, 0, 0, 0, 0, 0, 0);

        // Reset mid-run clears flags, keeps table
        do_reset();
        step(1, NOP, 0, 0, 0, 0, 0, 0);
        settle(1, 9'h1A3, 0, 0, 0, 0, 0, 0);
        check("rst_flag_clr", branch_en, 1'b1);
        check("rst_tbl_keep", bOFFSET, 9'd5);
        tick();
        step(1, NOP, 0, 0, 0, 0, 0, 0);

        // Abort has priority over a taken branch
        settle(0, 9'h1A3, 0, 0, 0, 0, 0, 0); check("abort_en", branch_en, 1'b0); tick();
        settle(0, NOP, 0, 0, 0, 0, 0, 0); check("abort_idle", init, 1'b1); tick();

        // Statistics: 3 taken branches over 10 RUN/FLUSH cycles, then HALT
        do_reset();
        step(1, NOP, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 9'h1A3, 0, 0, 0, 0, 0, 0);
            step(1, NOP, 0, 0, 0, 0, 0, 0);
        end
        for (int i = 0; i < 3; i++) step(1, NOP, 0, 0, 0, 0, 0, 0);
        step(1, 9'h1E0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) begin
            settle(1, NOP, 0, 0, 0, 0, 0, 0);
            check("stats_halted", halt, 1'b1);
`ifdef BRANCH_STATS_EN
            check("stats_taken", taken_cnt, 16'd3);
            check("stats_cycles", cycle_cnt, 16'd10);
`endif
            tick();
        end
        step(0, NOP, 0, 0, 0, 0, 0, 0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                case ($urandom_range(0, 4))
                    0: op = 4'hC;
                    1: op = 4'hD;
                    2: op = 4'hE;
                    3: op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
                    default: op = 4'($urandom_range(0, 11));
                endcase
                ri = {op, 5'($urandom)};
                step($urandom_range(0, 19) != 0, ri, 1'($urandom), 1'($urandom),
                     1'($urandom), $urandom_range(0, 3) == 0, 5'($urandom), 10'($urandom));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Branch and run-control stage directly upstream of the fetch PC register. Decodes the 9-bit instruction returned by the synchronous instruction ROM, evaluates branch conditions against a registered Z/N flag pair, and looks up signed branch offsets in a 32-entry table. Drives the PC register's `branch_en`/`bSIGN`/`bOFFSET`/`init`/`halt` inputs. Runs the start/done handshake with the testbench, squashing the wrong-path instruction after every taken branch.

## Interface
- `LUT_DEPTH`, 32: offset table entries (index = `instr[4:0]`)
- `OFF_W`, 9: offset magnitude width, matches `bOFFSET`
- `CLK` input 1: sole clock, rising edge
- `reset` input 1: asynchronous, active-high
- `start` input 1: testbench run request, level
- `instr` input 9: instruction from synchronous ROM (one cycle behind PC)
- `flag_we` input 1: ALU flag update strobe for current instruction
- `alu_zero` input 1: ALU result == 0
- `alu_neg` input 1: ALU result MSB
- `lut_we` input 1: offset table write strobe
- `lut_waddr` input 5: table write index
- `lut_wdata` input 10: `{sign, magnitude[8:0]}`
- `branch_en` output 1: take branch this cycle
- `bSIGN` output 1: 1 = backward (PC − offset)
- `bOFFSET` output 9: offset magnitude
- `init` output 1: hold PC register in init
- `halt` output 1: program stopped
- `squash` output 1: current `instr` is wrong-path; downstream must suppress writes
- `done` output 1: run complete, handshake acknowledge

## Operation
- Opcode = `instr[8:5]`: 4'hC BEQZ (taken if Z), 4'hD BNEZ (taken if !Z), 4'hE BLTZ (taken if N), 4'hF HALT; all others non-control.
- States: IDLE, RUN, FLUSH, HALTED.
- IDLE: `init`=1, `branch_en`=0. `start`=1 → RUN.
- RUN: `init`=0.
  - Taken branch → `branch_en`=1, `{bSIGN,bOFFSET}` = table[`instr[4:0]`], next FLUSH.
  - HALT → next HALTED.
  - Otherwise stay in RUN.
  - `start`=0 → IDLE (abort), takes priority over branch/halt; `branch_en` is 0 in that cycle.
- FLUSH: exactly one cycle. `squash`=1; `branch_en`=0; HALT and branch opcodes ignored; `flag_we` ignored. Next RUN, or IDLE if `start`=0.
- HALTED: `halt`=1, `done`=1, `init`=1. `start`=0 → IDLE.
- Flags Z/N update from `alu_zero`/`alu_neg` on the clock edge where `flag_we`=1 and state is RUN. Branch uses flags as registered before that edge, not same-cycle ALU values.
- Table writes accepted only in IDLE or HALTED; `lut_we` ignored in RUN/FLUSH. Table is not reset.
- Offset 0 with taken branch is legal (self-loop). Wrap-around is the PC register's concern.

## Timing
- Reset values: state IDLE, Z=N=0, `init`=1, `branch_en`=0, `bSIGN`=0, `bOFFSET`=0, `halt`=0, `squash`=0, `done`=0.
- `branch_en`, `bSIGN`, `bOFFSET` are combinational from state, `instr`, flags, and table. Valid before the edge that updates PC; zero when not taken.
- `init`, `halt`, `done`, `squash` are decoded from registered state only.
- Taken-branch penalty is 1 cycle (FLUSH).
- `halt`/`done` rise one cycle after HALT is decoded.
- `done` falls the cycle after `start` falls.
- Reset mid-run returns immediately to IDLE; flags clear, table keeps contents.

## Configuration
- `BRANCH_STATS_EN` defined: adds outputs `taken_cnt[15:0]` (taken branches) and `cycle_cnt[15:0]` (cycles in RUN+FLUSH).
  - Both reset to 0 and clear on the IDLE→RUN transition.
  - Both saturate at 16'hFFFF and hold in HALTED.
- `BRANCH_STATS_EN` undefined: those ports and counters are absent; all other behaviour is identical.

## Test plan
- Reset, write table[3]=10'h205, start=1, instr=9'h183 (BEQZ 3) with Z=1 → `branch_en`=1, `bSIGN`=1, `bOFFSET`=5; next cycle `squash`=1, `branch_en`=0.
- Z=0, instr=9'h183 → `branch_en`=0, state stays RUN, no squash; BNEZ 9'h1A3 in same conditions → taken.
- flag_we=1 with alu_neg=1 and BLTZ in the same cycle → not taken. BLTZ next cycle → taken.
- HALT 9'h1E0 in FLUSH cycle → ignored. HALT in RUN → next cycle `halt`=`done`=`init`=1. Drop start → `done`=0 next cycle, IDLE.
- `lut_we` during RUN to index 3 → table unchanged. Assert reset mid-RUN → IDLE, `init`=1, flags 0, table[3] still 10'h205.
- With `BRANCH_STATS_EN`: 3 taken branches over 10 run cycles then HALT → `taken_cnt`=3, `cycle_cnt`=10, held in HALTED.
